// File: rtl/regfile_dump_if.sv
// regfile_dump_if: control, regFile read port and dump stream signals of regfile_dump_unit.
interface regfile_dump_if #(parameter int DATA_WIDTH = 32, parameter int SEL_BITS = 5);
  logic                  start;
  logic                  abort;
  logic [SEL_BITS-1:0]   first_sel;
  logic [SEL_BITS-1:0]   last_sel;
  logic [SEL_BITS-1:0]   rf_read_sel;
  logic [DATA_WIDTH-1:0] rf_read_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [SEL_BITS-1:0]   dump_index;
  logic                  dump_last;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] checksum;
  modport master (
    input  start, abort, first_sel, last_sel, rf_read_data, dump_ready,
    output rf_read_sel, dump_valid, dump_data, dump_index, dump_last, busy, done, err, checksum
  );
  modport slave (
    output start, abort, first_sel, last_sel, rf_read_data, dump_ready,
    input  rf_read_sel, dump_valid, dump_data, dump_index, dump_last, busy, done, err, checksum
  );
endinterface

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: sweeps a register range through one regFile read port onto a valid/ready stream.
// Optional XOR checksum of accepted beats is enabled by defining DUMP_CHECKSUM_EN.
module regfile_dump_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BITS   = 5,
  parameter int NUM_REGS   = 32
) (
  input logic clock,
  input logic reset,
  regfile_dump_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FINISH} state_t;
  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d, last_q, last_d, sel_q, sel_d, index_q, index_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, dlast_q, dlast_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  range_ok, fire, abort_now, accept;
  assign range_ok  = bus.first_sel <= bus.last_sel && 32'(bus.last_sel) < NUM_REGS;
  assign fire      = state_q == SEND && valid_q && bus.dump_ready;
  assign abort_now = bus.abort && (state_q == ISSUE || state_q == CAPTURE || state_q == SEND);
  assign accept    = state_q == IDLE && bus.start && range_ok;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    index_d = index_q;
    dlast_d = dlast_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = range_ok ? ISSUE : FINISH;
        done_d  = !range_ok;
        err_d   = !range_ok;
        idx_d   = range_ok ? bus.first_sel : idx_q;
        last_d  = range_ok ? bus.last_sel : last_q;
        sel_d   = range_ok ? bus.first_sel : sel_q;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        data_d  = bus.rf_read_data;
        index_d = idx_q;
        dlast_d = idx_q == last_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (fire) begin
        valid_d = 1'b0;
        state_d = dlast_q ? FINISH : ISSUE;
        done_d  = dlast_q;
        idx_d   = dlast_q ? idx_q : idx_q + 1'b1;
        sel_d   = dlast_q ? sel_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort_now) begin
      state_d = FINISH;
      valid_d = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
    busy_d = state_d != IDLE;
  end
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  assign csum_d       = accept ? '0 : (fire && !abort_now) ? csum_q ^ data_q : csum_q;
  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      dlast_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      index_q <= index_d;
      dlast_q <= dlast_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  assign bus.rf_read_sel = sel_q;
  assign bus.dump_valid  = valid_q;
  assign bus.dump_data   = data_q;
  assign bus.dump_index  = index_q;
  assign bus.dump_last   = dlast_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: scoreboard bench for regfile_dump_unit against a combinational regFile model.
module tb_regfile_dump_unit;
  typedef struct {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } beat_t;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rf [32];
  beat_t       sb [$];
  int          n_checks = 0;
  int          n_fail = 0;
  regfile_dump_if #(.DATA_WIDTH(32), .SEL_BITS(5)) bus ();
  regfile_dump_unit #(.DATA_WIDTH(32), .SEL_BITS(5), .NUM_REGS(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  assign bus.rf_read_data = rf[bus.rf_read_sel];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"}, 64'(bus.rf_read_sel), 0);
    check({tag, "_valid"}, 64'(bus.dump_valid), 0);
    check({tag, "_data"}, 64'(bus.dump_data), 0);
    check({tag, "_index"}, 64'(bus.dump_index), 0);
    check({tag, "_last"}, 64'(bus.dump_last), 0);
    check({tag, "_busy"}, 64'(bus.busy), 0);
    check({tag, "_done"}, 64'(bus.done), 0);
    check({tag, "_err"}, 64'(bus.err), 0);
    check({tag, "_csum"}, 64'(bus.checksum), 0);
  endtask
  // mode 1 gives ready one cycle high, two low; ab/rs >= 0 abort or reset once that many beats are accepted
  task automatic run_dump(input int f, input int l, input int mode, input int ab, input int rs, input bit exp_err);
    int          acc;
    int          cyc;
    bit          fin;
    logic [31:0] xe;
    beat_t       e;
    acc = 0;
    cyc = 0;
    fin = 0;
    xe  = '0;
    if (!exp_err)
      for (int i = f; i <= l; i++) begin
        sb.push_back('{rf[i], 5'(i), i == l});
        xe ^= rf[i];
      end
    @(negedge clock);
    bus.start = 1'b1;
    bus.first_sel = 5'(f);
    bus.last_sel = 5'(l);
    @(negedge clock);
    bus.start = 1'b0;
    while (!fin && cyc < 600) begin
      bus.dump_ready = mode == 0 ? 1'b1 : (cyc % 3 == 0);
      if (ab >= 0 && acc == ab && bus.dump_valid) begin
        bus.dump_ready = 1'b0;
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        check("abort_valid", 64'(bus.dump_valid), 0);
        check("abort_done", 64'(bus.done), 1);
        check("abort_err", 64'(bus.err), 1);
        sb.delete();
        @(negedge clock);
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_done_once", 64'(bus.done), 0);
        fin = 1;
      end else if (rs >= 0 && acc == rs) begin
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("midreset");
        @(negedge clock);
        check("midreset_nodone", 64'(bus.done), 0);
        reset = 1'b1;
        sb.delete();
        fin = 1;
      end else begin
        if (bus.done) begin
          check("done_err", 64'(bus.err), 64'(exp_err));
          check("sb_empty", 64'(sb.size()), 0);
          if (exp_err) check("reject_latency", 64'(cyc <= 1), 1);
`ifdef DUMP_CHECKSUM_EN
          if (!exp_err) check("checksum", 64'(bus.checksum), 64'(xe));
`else
          check("checksum_tied", 64'(bus.checksum), 0);
`endif
          @(negedge clock);
          check("idle_busy", 64'(bus.busy), 0);
          check("done_pulse", 64'(bus.done), 0);
          fin = 1;
        end else if (bus.dump_valid) begin
          if (sb.size() == 0) check("extra_beat", 1, 0);
          else begin
            e = sb[0];
            check(bus.dump_ready ? "beat_data" : "stall_data", 64'(bus.dump_data), 64'(e.d));
            check(bus.dump_ready ? "beat_index" : "stall_index", 64'(bus.dump_index), 64'(e.i));
            check(bus.dump_ready ? "beat_last" : "stall_last", 64'(bus.dump_last), 64'(e.l));
            if (bus.dump_ready) begin
              void'(sb.pop_front());
              acc++;
            end
          end
        end
        if (!fin) begin
          check("busy_active", 64'(bus.busy), 1);
          @(negedge clock);
          cyc++;
        end
      end
    end
    if (!fin) check("timeout", 0, 1);
    sb.delete();
    bus.dump_ready = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(31 - i);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.first_sel = '0;
    bus.last_sel = '0;
    bus.dump_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("idle_abort_ignored", 64'(bus.done), 0);
    run_dump(1, 31, 0, -1, -1, 1'b0);
    run_dump(0, 0, 0, -1, -1, 1'b0);
    run_dump(5, 3, 0, -1, -1, 1'b1);
    run_dump(1, 4, 1, -1, -1, 1'b0);
    run_dump(1, 31, 0, 2, -1, 1'b0);
    run_dump(2, 3, 0, -1, -1, 1'b0);
    run_dump(1, 31, 0, -1, 5, 1'b0);
    run_dump(1, 31, 0, -1, -1, 1'b0);
    run_dump(30, 31, 1, -1, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
